xorshift_stream_checker: RTL and testbench
==========================================

// Module: xorshift_stream_checker
// PURPOSE
// - Receive end of the CPU data stream: takes the 64-bit words that N CPU producers emit, one word per clk when
//   data_vld is high, with no backpressure.
// - Buffers each channel, round-robin arbitrates into one compare stage, and checks each word against a per-CPU
//   xorshift64 reference model.
// - Reports match/mismatch counts, error details, overflow, and completion.
// PARAMETERS
// - NUM_CPU    4                      number of producer channels (1..16)
// - FIFO_DEPTH 4                      per-channel buffer depth, power of 2 (>=2)
// - NUM_TRANS  16                     words expected per channel
// - SEED_BASE  64'h9E3779B97F4A7C15   per-channel seed = SEED_BASE ^ {32'h0, idx}
// PORTS
// - clk          in   1              clock
// - rst          in   1              asynchronous reset, active-high
// - in_vld       in   NUM_CPU        per-channel word valid
// - in_data      in   NUM_CPU*64     channel i word at [64*i +: 64]
// - match_cnt    out  32             words equal to expected
// - mismatch_cnt out  32             words differing from expected
// - err_vld      out  1              1-cycle pulse per mismatch
// - err_idx      out  $clog2(NUM_CPU) channel of the mismatch (width 1 when NUM_CPU==1)
// - err_data     out  64             received word of the mismatch
// - err_exp      out  64             expected word of the mismatch
// - overflow     out  NUM_CPU        sticky, bit i set when a channel-i word is dropped
// - extra        out  NUM_CPU        sticky, bit i set when channel i sends more than NUM_TRANS words
// - all_done     out  1              all channels finished and drained
// BEHAVIOUR
// - Reset (async assert): all outputs 0; FIFOs empty; per-channel rx counters 0; arbiter pointer 0;
//   xorshift state[i] = SEED_BASE ^ i.
// - xorshift step: x ^= x<<13; x ^= x>>7; x ^= x<<17 (64-bit, truncate).
// - Expected word for channel i is step(state[i]). On each compare, state[i] <= step(state[i]).
//   The first expected word is step(seed).
// - Write side: in_vld[i] pushes in_data[i] into FIFO i.
//   - Full is judged on the count at the start of the cycle.
//   - A write to a full FIFO is dropped even if a pop happens in the same cycle, and sets overflow[i].
//   - Dropped words do not advance state[i] or the rx counter, so later words will mismatch.
// - Arbiter: each cycle, grant the first non-empty FIFO at or after the pointer (wrapping NUM_CPU-1 -> 0).
//   - Pop one word; pointer <= grant+1 mod NUM_CPU.
//   - No grant when all FIFOs are empty; the pointer holds.
// - Latency: a word written at cycle t is poppable at t+1 at the earliest.
//   The compare result (counters, err_*) is registered at pop cycle +1.
// - Compare stage, for a popped word on channel i:
//   - If rx_cnt[i] < NUM_TRANS: compare with the expected word, rx_cnt[i]++, step state[i].
//     - Equal: match_cnt++.
//     - Not equal: mismatch_cnt++, err_vld=1, err_idx/err_data/err_exp loaded.
//   - If rx_cnt[i] == NUM_TRANS: word discarded, extra[i] set, no counter change.
// - err_idx/err_data/err_exp hold their last value until the next mismatch. err_vld drops after 1 cycle.
// - Counters saturate at 32'hFFFFFFFF.
// - all_done = 1 when every rx_cnt == NUM_TRANS, all FIFOs are empty, and the compare stage is idle.
//   - Registered.
//   - Deasserts if a later extra word arrives, until that word drains.
// - Simultaneous in_vld on all channels in one cycle is legal. All words are accepted if their FIFO is not full.
// - Reset asserted mid-stream clears everything immediately, including in-flight compares.
//   No output pulse is generated on reset release.
// TESTING
// - Single channel (NUM_CPU=1): bench drives the 16 model words (seed ^ 0) with 1-cycle gaps
//   -> match_cnt=16, mismatch_cnt=0, all_done=1, overflow=0.
// - 4 channels, all in_vld every cycle for 16 cycles, each with its own sequence
//   -> arbiter drains 1 word/cycle; overflow sets on the channels that fill; later words on those channels
//   mismatch; match_cnt+mismatch_cnt equals the number of accepted words.
// - 4 channels, each valid 1 cycle in 4, staggered -> no overflow, match_cnt=64, all_done=1 one cycle after
//   the last compare.
// - Channel 2 word 5 flipped (bit 0 XOR)
//   -> exactly one err_vld pulse, err_idx=2, err_exp=model word, err_data=model^1, mismatch_cnt=1, match_cnt=63.
// - Channel 0 sends 17 words -> extra=4'b0001, match_cnt=64, mismatch_cnt=0.
// - Assert rst after 8 words/channel, then restart full sequences from seed
//   -> counters 0 immediately; final match_cnt=64, no errors.

Source files
------------

// File: rtl/xorshift_stream_checker.sv
// Receive-side checker for N xorshift64 producer streams: per-channel FIFOs, a round-robin
// arbiter and a single compare stage against a per-channel reference generator.
module xorshift_stream_checker #(
  parameter int          NUM_CPU    = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter int          NUM_TRANS  = 16,
  parameter logic [63:0] SEED_BASE  = 64'h9E3779B97F4A7C15,
  localparam int         IW         = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CPU-1:0]    in_vld,
  input  logic [NUM_CPU*64-1:0] in_data,
  output logic [31:0]           match_cnt,
  output logic [31:0]           mismatch_cnt,
  output logic                  err_vld,
  output logic [IW-1:0]         err_idx,
  output logic [63:0]           err_data,
  output logic [63:0]           err_exp,
  output logic [NUM_CPU-1:0]    overflow,
  output logic [NUM_CPU-1:0]    extra,
  output logic                  all_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(NUM_TRANS + 1);

  function automatic logic [63:0] xs_step(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  logic [63:0]   mem    [NUM_CPU][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [NUM_CPU];
  logic [AW-1:0] rd_ptr [NUM_CPU];
  logic [AW:0]   fcnt   [NUM_CPU];
  logic [CW-1:0] rx_cnt [NUM_CPU];
  logic [63:0]   state  [NUM_CPU];
  logic [IW-1:0] arb_ptr;

  logic [NUM_CPU-1:0] push;
  logic [NUM_CPU-1:0] pop;
  logic [NUM_CPU-1:0] not_empty;
  logic [NUM_CPU-1:0] rx_full;
  logic               grant_vld;
  logic [IW-1:0]      grant;
  logic [63:0]        pop_data;
  logic [63:0]        exp_word;

  // Fullness is judged on the start-of-cycle count, so a same-cycle pop never rescues a write.
  always_comb begin
    for (int i = 0; i < NUM_CPU; i++) begin
      not_empty[i] = (fcnt[i] != '0);
      push[i]      = in_vld[i] && (fcnt[i] != (AW+1)'(FIFO_DEPTH));
      rx_full[i]   = (rx_cnt[i] == CW'(NUM_TRANS));
      pop[i]       = grant_vld && (grant == IW'(i));
    end
  end

  // Scan downward so the last hit written is the first non-empty channel at or after the pointer.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = NUM_CPU - 1; k >= 0; k--) begin
      idx = (int'(arb_ptr) + k) % NUM_CPU;
      if (not_empty[idx]) begin
        grant_vld = 1'b1;
        grant     = IW'(idx);
      end
    end
  end

  assign pop_data = mem[grant][rd_ptr[grant]];
  assign exp_word = xs_step(state[grant]);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CPU; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[64*i +: 64];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CPU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        fcnt[i]   <= '0;
        rx_cnt[i] <= '0;
        state[i]  <= SEED_BASE ^ 64'(i);
      end
      arb_ptr      <= '0;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      err_vld      <= 1'b0;
      err_idx      <= '0;
      err_data     <= '0;
      err_exp      <= '0;
      overflow     <= '0;
      extra        <= '0;
      all_done     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CPU; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (in_vld[i] && !push[i]) overflow[i] <= 1'b1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
        fcnt[i] <= fcnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end

      err_vld <= 1'b0;
      if (grant_vld) begin
        arb_ptr <= (grant == IW'(NUM_CPU - 1)) ? '0 : grant + IW'(1);
        // Words beyond the expected count are discarded without touching the reference state.
        if (rx_cnt[grant] < CW'(NUM_TRANS)) begin
          rx_cnt[grant] <= rx_cnt[grant] + CW'(1);
          state[grant]  <= exp_word;
          if (pop_data == exp_word) begin
            if (match_cnt != 32'hFFFFFFFF) match_cnt <= match_cnt + 32'd1;
          end else begin
            if (mismatch_cnt != 32'hFFFFFFFF) mismatch_cnt <= mismatch_cnt + 32'd1;
            err_vld  <= 1'b1;
            err_idx  <= grant;
            err_data <= pop_data;
            err_exp  <= exp_word;
          end
        end else begin
          extra[grant] <= 1'b1;
        end
      end

      all_done <= (&rx_full) && !(|not_empty) && !grant_vld;
    end
  end

endmodule

// File: tb/tb_xorshift_stream_checker.sv
// Directed bench for xorshift_stream_checker: a 4-channel and a 1-channel instance driven with
// reference xorshift64 sequences, plus table-driven staggered-stream scenarios.
module tb_xorshift_stream_checker;

  localparam logic [63:0] SEED = 64'h9E3779B97F4A7C15;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_vld;
  logic [255:0] in_data;
  logic [31:0]  match_cnt, mismatch_cnt;
  logic         err_vld;
  logic [1:0]   err_idx;
  logic [63:0]  err_data, err_exp;
  logic [3:0]   overflow, extra;
  logic         all_done;

  logic         in_vld1;
  logic [63:0]  in_data1;
  logic [31:0]  match_cnt1, mismatch_cnt1;
  logic         err_vld1;
  logic [0:0]   err_idx1;
  logic [63:0]  err_data1, err_exp1;
  logic [0:0]   overflow1, extra1;
  logic         all_done1;

  int tests_run = 0;
  int tests_failed = 0;
  int err_pulses = 0;

  always #5 clk = ~clk;

  xorshift_stream_checker #(.NUM_CPU(4)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data),
    .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .err_vld(err_vld),
    .err_idx(err_idx), .err_data(err_data), .err_exp(err_exp),
    .overflow(overflow), .extra(extra), .all_done(all_done)
  );

  xorshift_stream_checker #(.NUM_CPU(1)) dut1 (
    .clk(clk), .rst(rst), .in_vld(in_vld1), .in_data(in_data1),
    .match_cnt(match_cnt1), .mismatch_cnt(mismatch_cnt1), .err_vld(err_vld1),
    .err_idx(err_idx1), .err_data(err_data1), .err_exp(err_exp1),
    .overflow(overflow1), .extra(extra1), .all_done(all_done1)
  );

  always @(negedge clk) if (err_vld) err_pulses <= err_pulses + 1;

  function automatic logic [63:0] xs_step(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  // Word k (0-based) of channel ch: k+1 steps from that channel's seed.
  function automatic logic [63:0] model_word(input int ch, input int k);
    logic [63:0] x;
    x = SEED ^ 64'(ch);
    for (int i = 0; i <= k; i++) x = xs_step(x);
    return x;
  endfunction

  typedef struct {
    string       name;
    int          flip_ch;
    int          flip_k;
    int          extra_ch;
    logic [31:0] exp_match;
    logic [31:0] exp_mismatch;
    logic [3:0]  exp_extra;
    logic        exp_done;
    int          exp_errs;
  } vec_t;

  vec_t vecs[3];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    in_vld  = '0;
    in_vld1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Channel c%4 sends its word c/4 every cycle, optionally with one bit-0 flip and one extra word.
  task automatic applyStimulus(input int words, input int flip_ch, input int flip_k, input int extra_ch);
    int ch, k;
    for (int c = 0; c < 4 * words; c++) begin
      @(negedge clk);
      ch = c % 4;
      k  = c / 4;
      in_vld  = 4'(1 << ch);
      in_data = '0;
      in_data[64*ch +: 64] = model_word(ch, k) ^ (((ch == flip_ch) && (k == flip_k)) ? 64'd1 : 64'd0);
    end
    if (extra_ch >= 0) begin
      @(negedge clk);
      in_vld  = 4'(1 << extra_ch);
      in_data = '0;
      in_data[64*extra_ch +: 64] = model_word(extra_ch, words);
    end
    @(negedge clk);
    in_vld = '0;
  endtask

  initial begin
    int  base;
    bit  seen;
    logic done_at_last;

    vecs[0] = '{"clean",   -1, -1, -1, 32'd64, 32'd0, 4'b0000, 1'b1, 0};
    vecs[1] = '{"flip2_5",  2,  5, -1, 32'd63, 32'd1, 4'b0000, 1'b1, 1};
    vecs[2] = '{"extra0",  -1, -1,  0, 32'd64, 32'd0, 4'b0001, 1'b1, 0};

    rst = 1'b1; in_vld = '0; in_data = '0; in_vld1 = 1'b0; in_data1 = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_match",    64'(match_cnt), 64'd0);
    checkOutput("rst_mismatch", 64'(mismatch_cnt), 64'd0);
    checkOutput("rst_err_vld",  64'(err_vld), 64'd0);
    checkOutput("rst_err_data", err_data, 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_extra",    64'(extra), 64'd0);
    checkOutput("rst_all_done", 64'(all_done), 64'd0);
    rst = 1'b0;

    // Single channel, one idle cycle between words.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); in_vld1 = 1'b1; in_data1 = model_word(0, k);
      @(negedge clk); in_vld1 = 1'b0;
    end
    repeat (4) @(negedge clk);
    checkOutput("one_match",    64'(match_cnt1), 64'd16);
    checkOutput("one_mismatch", 64'(mismatch_cnt1), 64'd0);
    checkOutput("one_all_done", 64'(all_done1), 64'd1);
    checkOutput("one_overflow", 64'(overflow1), 64'd0);

    // all_done must rise exactly one cycle after the final compare result appears.
    do_reset();
    applyStimulus(16, -1, -1, -1);
    seen = 1'b0;
    done_at_last = 1'b1;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (match_cnt == 32'd64) begin
        seen = 1'b1;
        done_at_last = all_done;
      end
    end
    checkOutput("timing_seen_64", 64'(seen), 64'd1);
    checkOutput("timing_done_early", 64'(done_at_last), 64'd0);
    @(negedge clk);
    checkOutput("timing_done_next", 64'(all_done), 64'd1);
    checkOutput("timing_overflow", 64'(overflow), 64'd0);

    for (int v = 0; v < 3; v++) begin
      do_reset();
      base = err_pulses;
      applyStimulus(16, vecs[v].flip_ch, vecs[v].flip_k, vecs[v].extra_ch);
      repeat (8) @(negedge clk);
      checkOutput({vecs[v].name, "_match"},    64'(match_cnt), 64'(vecs[v].exp_match));
      checkOutput({vecs[v].name, "_mismatch"}, 64'(mismatch_cnt), 64'(vecs[v].exp_mismatch));
      checkOutput({vecs[v].name, "_extra"},    64'(extra), 64'(vecs[v].exp_extra));
      checkOutput({vecs[v].name, "_overflow"}, 64'(overflow), 64'd0);
      checkOutput({vecs[v].name, "_done"},     64'(all_done), 64'(vecs[v].exp_done));
      checkOutput({vecs[v].name, "_pulses"},   64'(err_pulses - base), 64'(vecs[v].exp_errs));
      if (vecs[v].exp_errs > 0) begin
        checkOutput({vecs[v].name, "_err_idx"},  64'(err_idx), 64'(vecs[v].flip_ch));
        checkOutput({vecs[v].name, "_err_exp"},  err_exp, model_word(vecs[v].flip_ch, vecs[v].flip_k));
        checkOutput({vecs[v].name, "_err_data"}, err_data,
                    model_word(vecs[v].flip_ch, vecs[v].flip_k) ^ 64'd1);
        checkOutput({vecs[v].name, "_err_vld_low"}, 64'(err_vld), 64'd0);
      end
    end

    // All four channels valid for 16 cycles: 30 words accepted, 19 in order, 11 out of step.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      in_vld = 4'hF;
      for (int ch = 0; ch < 4; ch++) in_data[64*ch +: 64] = model_word(ch, c);
    end
    @(negedge clk);
    in_vld = '0;
    repeat (30) @(negedge clk);
    checkOutput("burst_overflow", 64'(overflow), 64'hF);
    checkOutput("burst_match",    64'(match_cnt), 64'd19);
    checkOutput("burst_mismatch", 64'(mismatch_cnt), 64'd11);
    checkOutput("burst_total",    64'(match_cnt + mismatch_cnt), 64'd30);
    checkOutput("burst_extra",    64'(extra), 64'd0);
    checkOutput("burst_done",     64'(all_done), 64'd0);

    // Reset in the middle of a stream, then a full restart from the seeds.
    do_reset();
    base = err_pulses;
    applyStimulus(8, -1, -1, -1);
    checkOutput("mid_nonzero", 64'(match_cnt != 32'd0), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_match",    64'(match_cnt), 64'd0);
    checkOutput("mid_rst_mismatch", 64'(mismatch_cnt), 64'd0);
    checkOutput("mid_rst_done",     64'(all_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16, -1, -1, -1);
    repeat (8) @(negedge clk);
    checkOutput("restart_match",    64'(match_cnt), 64'd64);
    checkOutput("restart_mismatch", 64'(mismatch_cnt), 64'd0);
    checkOutput("restart_pulses",   64'(err_pulses - base), 64'd0);
    checkOutput("restart_done",     64'(all_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
